// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM slave: word-organised memory with byte/half/word writes,
// programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_ram_slave #(
  parameter int DATA_WDT    = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic                o_hreadyout,
  output logic [1:0]          o_hresp,
  output logic [DATA_WDT-1:0] o_hrdata
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  WS         = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                r_pend;
  logic                w_pend_nxt;
  logic                r_write;
  logic [1:0]          r_size;
  logic [AW+1:0]       r_addr;
  logic [DATA_WDT-1:0] r_rdata;
  logic [DATA_WDT-1:0] r_mem [DEPTH];

  logic                w_hreadyout;
  logic                w_accept;
  logic                w_err;
  logic                w_complete;
  logic                w_wr_commit;
  logic [3:0]          w_be;
  logic [AW-1:0]       w_new_idx;
  logic [AW-1:0]       w_cur_idx;
  logic                w_hit;
  logic [DATA_WDT-1:0] w_rd_merged;
  logic                w_unused;

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  assign w_hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign o_hreadyout = w_hreadyout;
  assign o_hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? 2'b01 : 2'b00;

  // Address phases are ignored while this slave stalls the bus.
  assign w_accept    = i_hsel && i_htrans[1] && i_hready && w_hreadyout;
  assign w_complete  = (r_state == ST_IDLE) && r_pend;
  assign w_wr_commit = w_complete && r_write;
  assign w_be        = f_be(r_size, r_addr[1:0]) & {4{w_wr_commit}};
  assign w_new_idx   = i_haddr[AW+1:2];
  assign w_cur_idx   = r_addr[AW+1:2];
  assign w_hit       = w_wr_commit && (w_cur_idx == w_new_idx);
  assign o_hrdata    = (w_complete && !r_write) ? r_rdata : '0;
  assign w_unused    = &{1'b0, i_hburst, i_htrans[0]};

  always_comb begin
    w_err = ({1'b0, i_haddr} >= ADDR_LIMIT);
    case (i_hsize)
      3'd0:    w_err = w_err;
      3'd1:    w_err = w_err || i_haddr[0];
      3'd2:    w_err = w_err || (|i_haddr[1:0]);
      default: w_err = 1'b1;
    endcase
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    case (r_state)
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = ST_IDLE;
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: begin
        w_state_nxt = ST_IDLE;
        if (w_complete) w_pend_nxt = 1'b0;
        if (w_accept) begin
          w_pend_nxt = !w_err;
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (WS != 4'd0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WS;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      if (w_accept) begin
        r_write <= i_hwrite;
        r_size  <= i_hsize[1:0];
        r_addr  <= i_haddr[AW+1:0];
      end
    end
  end

  // A read accepted on the edge that commits a write to the same word sees the new bytes.
  always_comb begin
    w_rd_merged = r_mem[w_new_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_hit && w_be[b]) w_rd_merged[b*8 +: 8] = i_hwdata[b*8 +: 8];
    end
  end

  // NOTE: the memory array and its read register are deliberately not reset so they map to RAM.
  always_ff @(posedge i_hclk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) r_mem[w_cur_idx][b*8 +: 8] <= i_hwdata[b*8 +: 8];
    end
    if (w_accept && !w_err && !i_hwrite) r_rdata <= w_rd_merged;
  end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave: three instances (0, 3 and 5 wait states)
// share one bus; only the instance chosen by r_sel is selected.
module tb_ahb_ram_slave;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        r_hsel;
  logic [1:0]  r_sel;
  logic        r_rnd;
  logic        hready;
  logic [2:0]  hsel_v;
  logic [2:0]  rdy;
  logic [1:0]  resp0, resp1, resp2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic        cur_rdy;
  logic [1:0]  cur_resp;
  logic [31:0] cur_rdata;

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  assign hsel_v[0] = r_hsel && (r_sel == 2'd0);
  assign hsel_v[1] = r_hsel && (r_sel == 2'd1);
  assign hsel_v[2] = r_hsel && (r_sel == 2'd2);
  assign cur_rdy   = (r_sel == 2'd2) ? rdy[2] : (r_sel == 2'd1) ? rdy[1] : rdy[0];
  assign cur_resp  = (r_sel == 2'd2) ? resp2 : (r_sel == 2'd1) ? resp1 : resp0;
  assign cur_rdata = (r_sel == 2'd2) ? rdata2 : (r_sel == 2'd1) ? rdata1 : rdata0;
  assign hready    = cur_rdy && r_rnd;

  ahb_ram_slave #(.DATA_WDT(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .i_hclk(hclk), .i_hreset_n(hreset_n), .i_hsel(hsel_v[0]), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
    .i_hwdata(hwdata), .i_hready(hready), .o_hreadyout(rdy[0]), .o_hresp(resp0),
    .o_hrdata(rdata0));

  ahb_ram_slave #(.DATA_WDT(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .i_hclk(hclk), .i_hreset_n(hreset_n), .i_hsel(hsel_v[1]), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
    .i_hwdata(hwdata), .i_hready(hready), .o_hreadyout(rdy[1]), .o_hresp(resp1),
    .o_hrdata(rdata1));

  ahb_ram_slave #(.DATA_WDT(32), .DEPTH(1024), .WAIT_STATES(5)) u_ws5 (
    .i_hclk(hclk), .i_hreset_n(hreset_n), .i_hsel(hsel_v[2]), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
    .i_hwdata(hwdata), .i_hready(hready), .o_hreadyout(rdy[2]), .o_hresp(resp2),
    .o_hrdata(rdata2));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Single NONSEQ transfer; called at a negedge, returns at the negedge of the completing cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input int exp_waits, input string tag);
    int          waits;
    logic [1:0]  resp_or;
    logic [31:0] rd_in_wait;
    haddr  = addr;
    hwrite = wr;
    hsize  = sz;
    hburst = 3'b000;
    htrans = HT_NONSEQ;
    r_hsel = 1'b1;
    r_rnd  = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    htrans = HT_IDLE;
    r_hsel = 1'b0;
    if (wr) hwdata = wdata;
    waits      = 0;
    resp_or    = 2'b00;
    rd_in_wait = '0;
    while (!cur_rdy && waits < 40) begin
      resp_or    = resp_or | cur_resp;
      rd_in_wait = rd_in_wait | cur_rdata;
      waits++;
      @(negedge hclk);
    end
    resp_or = resp_or | cur_resp;
    check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
    check({tag, "_resp"}, 32'(resp_or), 32'd0);
    check({tag, "_rdata"}, cur_rdata, wr ? 32'd0 : exp_rd);
    if (exp_waits > 0) check({tag, "_rdata_in_wait"}, rd_in_wait, 32'd0);
  endtask

  // Illegal write; returns at the negedge of the ERR2 cycle so the caller can pipeline.
  task automatic err_xfer(input logic [31:0] addr, input logic [2:0] sz, input string tag);
    haddr  = addr;
    hwrite = 1'b1;
    hsize  = sz;
    htrans = HT_NONSEQ;
    r_hsel = 1'b1;
    r_rnd  = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    htrans = HT_IDLE;
    r_hsel = 1'b0;
    hwdata = 32'hFFFF_FFFF;
    check({tag, "_err1_rdy"}, 32'(cur_rdy), 32'd0);
    check({tag, "_err1_resp"}, 32'(cur_resp), 32'd1);
    @(negedge hclk);
    check({tag, "_err2_rdy"}, 32'(cur_rdy), 32'd1);
    check({tag, "_err2_resp"}, 32'(cur_resp), 32'd1);
  endtask

  task automatic burst(input logic [31:0] base, input string tag);
    logic [31:0] d [42];
    int k;
    int pend;
    int cyc;
    foreach (d[i]) d[i] = $urandom;
    hburst = 3'b001;
    hwrite = 1'b1;
    hsize  = 3'd2;
    k      = 0;
    cyc    = 0;
    while (k < 42 && cyc < 1000) begin
      haddr  = base + 32'(k * 4);
      htrans = (k == 0) ? HT_NONSEQ : HT_SEQ;
      r_hsel = 1'b1;
      if (k > 0) hwdata = d[k-1];
      r_rnd = ($urandom_range(0, 3) != 0);
      @(posedge hclk);
      if (r_rnd) k++;
      @(negedge hclk);
      cyc++;
    end
    htrans = HT_IDLE;
    r_hsel = 1'b0;
    r_rnd  = 1'b1;
    hwdata = d[41];
    @(posedge hclk);
    @(negedge hclk);
    check({tag, "_wr_beats"}, 32'(k), 32'd42);

    hwrite = 1'b0;
    k      = 0;
    pend   = -1;
    cyc    = 0;
    while ((k < 42 || pend >= 0) && cyc < 1000) begin
      if (pend >= 0) begin
        check($sformatf("%s_rd%0d", tag, pend), cur_rdata, d[pend]);
        pend = -1;
      end
      if (k < 42) begin
        haddr  = base + 32'(k * 4);
        htrans = (k == 0) ? HT_NONSEQ : HT_SEQ;
        r_hsel = 1'b1;
        r_rnd  = ($urandom_range(0, 3) != 0);
      end else begin
        htrans = HT_IDLE;
        r_hsel = 1'b0;
        r_rnd  = 1'b1;
      end
      @(posedge hclk);
      if (k < 42 && r_rnd) begin
        pend = k;
        k++;
      end
      @(negedge hclk);
      cyc++;
    end
    htrans = HT_IDLE;
    r_hsel = 1'b0;
    r_rnd  = 1'b1;
    hburst = 3'b000;
    check({tag, "_rd_beats"}, 32'(k), 32'd42);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    haddr    = '0;
    htrans   = HT_IDLE;
    hwrite   = 1'b0;
    hsize    = 3'd2;
    hburst   = 3'b000;
    hwdata   = '0;
    r_hsel   = 1'b0;
    r_sel    = 2'd0;
    r_rnd    = 1'b1;
    hreset_n = 1'b0;

    repeat (3) @(negedge hclk);
    check("rst_rdy_ws0", 32'(rdy[0]), 32'd1);
    check("rst_resp_ws0", 32'(resp0), 32'd0);
    check("rst_rdata_ws0", rdata0, 32'd0);
    check("rst_rdy_ws5", 32'(rdy[2]), 32'd1);
    check("rst_resp_ws5", 32'(resp2), 32'd0);
    check("rst_rdata_ws5", rdata2, 32'd0);
    hreset_n = 1'b1;

    // Zero wait states: write then immediately read the same word.
    xfer(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 32'd0, 0, "w10");
    xfer(1'b0, 32'h10, 3'd2, 32'd0, 32'hDEAD_BEEF, 0, "r10");

    // Sub-word lane steering.
    xfer(1'b1, 32'h0, 3'd2, 32'h1122_3344, 32'd0, 0, "w0");
    xfer(1'b1, 32'h2, 3'd0, 32'h00AA_0000, 32'd0, 0, "wbyte2");
    xfer(1'b0, 32'h0, 3'd2, 32'd0, 32'h11AA_3344, 0, "rbyte");
    xfer(1'b1, 32'h4, 3'd2, 32'h5566_7788, 32'd0, 0, "w4");
    xfer(1'b1, 32'h6, 3'd1, 32'hCAFE_0000, 32'd0, 0, "whalf6");
    xfer(1'b0, 32'h4, 3'd2, 32'd0, 32'hCAFE_7788, 0, "rhalf");

    // Last valid word, then illegal accesses each followed by a read issued during ERR2.
    xfer(1'b1, 32'hFFC, 3'd2, 32'h0F0F_1234, 32'd0, 0, "wlast");
    xfer(1'b0, 32'hFFC, 3'd2, 32'd0, 32'h0F0F_1234, 0, "rlast");
    err_xfer(32'h1000, 3'd2, "e1000");
    xfer(1'b0, 32'h0, 3'd2, 32'd0, 32'h11AA_3344, 0, "r0_after_e1000");
    err_xfer(32'h3, 3'd1, "ehalf3");
    xfer(1'b0, 32'h0, 3'd2, 32'd0, 32'h11AA_3344, 0, "r0_after_ehalf3");
    err_xfer(32'h8, 3'd3, "esize3");
    xfer(1'b0, 32'hFFC, 3'd2, 32'd0, 32'h0F0F_1234, 0, "rlast_after_esize3");

    // Three wait states.
    r_sel = 2'd1;
    xfer(1'b1, 32'h20, 3'd2, 32'hA5A5_0F0F, 32'd0, 3, "w20_ws3");
    xfer(1'b0, 32'h20, 3'd2, 32'd0, 32'hA5A5_0F0F, 3, "r20_ws3");

    // Five wait states with reset asserted in the second wait cycle of a write.
    r_sel = 2'd2;
    xfer(1'b1, 32'h40, 3'd2, 32'h1234_5678, 32'd0, 5, "w40_ws5");
    haddr  = 32'h40;
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = HT_NONSEQ;
    r_hsel = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    htrans = HT_IDLE;
    r_hsel = 1'b0;
    hwdata = 32'h8765_4321;
    check("abort_wait1_rdy", 32'(cur_rdy), 32'd0);
    @(negedge hclk);
    check("abort_wait2_rdy", 32'(cur_rdy), 32'd0);
    hreset_n = 1'b0;
    #1;
    check("abort_rst_rdy", 32'(cur_rdy), 32'd1);
    check("abort_rst_resp", 32'(cur_resp), 32'd0);
    check("abort_rst_rdata", cur_rdata, 32'd0);
    repeat (2) @(negedge hclk);
    hreset_n = 1'b1;
    xfer(1'b0, 32'h40, 3'd2, 32'd0, 32'h1234_5678, 5, "r40_after_rst");

    // Pipelined INCR burst with random bus stalls.
    r_sel = 2'd0;
    burst(32'h200, "burst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
